cam_sched: RTL and testbench

Sequencer for the IR camera's I2C transaction engine. Drives the camera's reset pin and holds it through power-up. Issues the one-time configuration transaction, then polls blob-data reads at a fixed period, with retry, reinitialisation and fault handling. Sits between the top level and the `camera` engine, owning that engine's `start` and `cam_reset`, so the engine never needs its own sequencing.

---
 rtl/cam_sched_pkg.sv | 39 +++
 rtl/cam_sched_timer.sv | 41 ++++
 rtl/cam_sched.sv | 147 ++++++++++++++
 tb/tb_cam_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_sched_pkg.sv
// cam_sched shared definitions: state encoding, transfer types, counter sizing.
// Used by cam_sched and cam_sched_timer.
package cam_sched_pkg;

    localparam logic [2:0] ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] ST_SETTLE     = 3'd1;
    localparam logic [2:0] ST_CFG_START  = 3'd2;
    localparam logic [2:0] ST_CFG_WAIT   = 3'd3;
    localparam logic [2:0] ST_IDLE       = 3'd4;
    localparam logic [2:0] ST_RD_START   = 3'd5;
    localparam logic [2:0] ST_RD_WAIT    = 3'd6;
    localparam logic [2:0] ST_FAULT      = 3'd7;

    typedef enum logic [2:0] {
        RESET_HOLD = ST_RESET_HOLD,
        SETTLE     = ST_SETTLE,
        CFG_START  = ST_CFG_START,
        CFG_WAIT   = ST_CFG_WAIT,
        IDLE       = ST_IDLE,
        RD_START   = ST_RD_START,
        RD_WAIT    = ST_RD_WAIT,
        FAULT      = ST_FAULT
    } state_e;

    localparam logic CAM_XFER_CONFIG = 1'b1;
    localparam logic CAM_XFER_READ   = 1'b0;

    // Bits needed to hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cam_sched_timer.sv
// Poll interval generator: free-running 0..POLL_PERIOD-1 counter with a
// combinational wrap pulse on the last count.
module cam_sched_timer
    import cam_sched_pkg::*;
#(
    parameter int POLL_PERIOD = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic wrap
);

    localparam int PW = cnt_w(POLL_PERIOD - 1);
    localparam logic [PW-1:0] LAST = PW'(POLL_PERIOD - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign wrap = run && (cnt_q == LAST);

    // Next poll count: clear wins, otherwise count and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Poll count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cam_sched.sv
// IR camera transaction sequencer: reset hold, settle, config, periodic reads.
// Define CAM_WATCHDOG_EN to turn a stuck transaction into a NACK.
module cam_sched
    import cam_sched_pkg::*;
#(
    parameter int RESET_CYCLES   = 1000,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int POLL_PERIOD    = 100000,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cam_done,
    input  logic cam_nack,
    output logic cam_reset,
    output logic cam_start,
    output logic cam_config,
    output logic frame_valid,
    output logic ready,
    output logic error
);

    localparam int CW = cnt_w(max3(RESET_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES));
    localparam int RW = cnt_w(MAX_RETRIES);
    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic cam_reset_q, cam_reset_d;
    logic cam_start_q, cam_start_d;
    logic cam_config_q, cam_config_d;
    logic frame_valid_q, frame_valid_d;
    logic ready_q, ready_d;
    logic error_q, error_d;
    logic poll_run, poll_wrap, timeout, done_ok, done_bad;

    assign poll_run = state_q inside {IDLE, RD_START, RD_WAIT};

    cam_sched_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(!poll_run),
        .run  (poll_run),
        .wrap (poll_wrap)
    );

`ifdef CAM_WATCHDOG_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);
    // cnt_q is zero on the START cycle, so this fires TIMEOUT_CYCLES later.
    assign timeout = (state_q inside {CFG_WAIT, RD_WAIT}) &&
                     (cnt_q == TIMEOUT_LAST) && !cam_done;
`else
    assign timeout = 1'b0;
`endif

    assign done_ok   = cam_done && !cam_nack;
    assign done_bad  = (cam_done && cam_nack) || timeout;
    assign retry_inc = retry_q + 1'b1;

    // Next state, delay/retry counters and registered output values.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        unique case (state_q)
            RESET_HOLD: if (cnt_q == RESET_LAST) state_d = SETTLE;
            SETTLE:     if (cnt_q == SETTLE_LAST) state_d = CFG_START;
            CFG_START:  state_d = CFG_WAIT;
            CFG_WAIT: begin
                if (done_ok) begin
                    retry_d = '0;
                    state_d = IDLE;
                end else if (done_bad) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < RETRY_MAX) ? RESET_HOLD : FAULT;
                end
            end
            IDLE:       if (poll_wrap && enable) state_d = RD_START;
            RD_START:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (done_ok) begin
                    retry_d = '0;
                    state_d = IDLE;
                end else if (done_bad) begin
                    if (retry_inc >= RETRY_MAX) begin
                        retry_d = '0;
                        state_d = RESET_HOLD;
                    end else begin
                        retry_d = retry_inc;
                        state_d = IDLE;
                    end
                end
            end
            FAULT:      state_d = FAULT;
        endcase
        // The WAIT states keep counting from their START cycle.
        if (state_d != state_q && !(state_d inside {CFG_WAIT, RD_WAIT})) begin
            cnt_d = '0;
        end
        cam_reset_d   = !(state_d inside {RESET_HOLD, FAULT});
        cam_start_d   = state_d inside {CFG_START, RD_START};
        cam_config_d  = (state_d == CFG_START) ? CAM_XFER_CONFIG : CAM_XFER_READ;
        frame_valid_d = (state_q == RD_WAIT) && done_ok;
        ready_d       = state_d == IDLE;
        error_d       = state_d == FAULT;
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RESET_HOLD;
            cnt_q         <= '0;
            retry_q       <= '0;
            cam_reset_q   <= 1'b0;
            cam_start_q   <= 1'b0;
            cam_config_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            cam_reset_q   <= cam_reset_d;
            cam_start_q   <= cam_start_d;
            cam_config_q  <= cam_config_d;
            frame_valid_q <= frame_valid_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
        end
    end

    assign cam_reset   = cam_reset_q;
    assign cam_start   = cam_start_q;
    assign cam_config  = cam_config_q;
    assign frame_valid = frame_valid_q;
    assign ready       = ready_q;
    assign error       = error_q;

endmodule

// File: tb/tb_cam_sched.sv
// Scoreboard bench for cam_sched: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cam_sched;

    localparam int RC = 4;
    localparam int SC = 8;
    localparam int PP = 50;
    localparam int TC = 20;
    localparam int MR = 2;

    localparam int K_CFG  = 0;
    localparam int K_RD   = 1;
    localparam int K_FV   = 2;
    localparam int K_RDY  = 3;
    localparam int K_RISE = 4;
    localparam int K_FALL = 5;
    localparam int K_ERR  = 6;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic cam_done = 1'b0;
    logic cam_nack = 1'b0;
    logic cam_reset, cam_start, cam_config, frame_valid, ready, error;
    logic p_rst, p_rdy, p_err;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int b = 0;
    int a = 0;
    ev_t exp_q[$];

    cam_sched #(
        .RESET_CYCLES  (RC),
        .SETTLE_CYCLES (SC),
        .POLL_PERIOD   (PP),
        .TIMEOUT_CYCLES(TC),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cam_done   (cam_done),
        .cam_nack   (cam_nack),
        .cam_reset  (cam_reset),
        .cam_start  (cam_start),
        .cam_config (cam_config),
        .frame_valid(frame_valid),
        .ready      (ready),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_CFG:   return "cfg_start";
            K_RD:    return "rd_start";
            K_FV:    return "frame_valid";
            K_RDY:   return "ready_rise";
            K_RISE:  return "cam_reset_rise";
            K_FALL:  return "cam_reset_fall";
            K_ERR:   return "error_rise";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic see(input int k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s at cycle %0d, none expected", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                bad++;
                $display("FAIL event: got %s@%0d want %s@%0d", kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cam_start && cam_config) see(K_CFG);
        if (cam_start && !cam_config) see(K_RD);
        if (frame_valid) see(K_FV);
        if (ready && !p_rdy) see(K_RDY);
        if (cam_reset && !p_rst) see(K_RISE);
        if (!cam_reset && p_rst) see(K_FALL);
        if (error && !p_err) see(K_ERR);
        p_rst = cam_reset;
        p_rdy = ready;
        p_err = error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input int n, input logic nack);
        goto(n);
        cam_done = 1'b1;
        cam_nack = nack;
        @(posedge clk);
        #1;
        cam_done = 1'b0;
        cam_nack = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        b = cyc;
        check("reset_cam_reset", {31'd0, cam_reset}, 32'd0);
        check("reset_outputs", {27'd0, cam_start, cam_config, frame_valid, ready, error}, 32'd0);
    endtask

    initial begin
        do_reset(3);
        a = b;
        enable = 1'b1;
        expect_ev(K_RISE, a + 4);
        expect_ev(K_CFG, a + 13);
        expect_ev(K_RDY, a + 19);
        pulse_done(a + 18, 1'b0);

        expect_ev(K_RD, a + 69);
        expect_ev(K_FV, a + 73);
        expect_ev(K_RDY, a + 73);
        pulse_done(a + 72, 1'b0);

        expect_ev(K_RD, a + 119);
        goto(a + 121);
        enable = 1'b0;
        expect_ev(K_FV, a + 126);
        expect_ev(K_RDY, a + 126);
        pulse_done(a + 125, 1'b0);
        goto(a + 130);
        enable = 1'b1;

        expect_ev(K_RD, a + 169);
        expect_ev(K_RDY, a + 173);
        pulse_done(a + 172, 1'b1);

        expect_ev(K_RD, a + 219);
        expect_ev(K_FV, a + 223);
        expect_ev(K_RDY, a + 223);
        pulse_done(a + 222, 1'b0);

        expect_ev(K_RD, a + 269);
        expect_ev(K_RDY, a + 272);
        pulse_done(a + 271, 1'b1);

        expect_ev(K_RD, a + 319);
        expect_ev(K_FALL, a + 323);
        expect_ev(K_RISE, a + 327);
        expect_ev(K_CFG, a + 336);
        pulse_done(a + 322, 1'b1);

        expect_ev(K_RDY, a + 341);
        pulse_done(a + 340, 1'b0);

        goto(a + 345);
        enable = 1'b0;
        pulse_done(a + 350, 1'b0);
        goto(a + 355);
        cam_nack = 1'b1;
        @(posedge clk);
        #1;
        cam_nack = 1'b0;
        goto(a + 395);
        check("idle_hold_ready", {31'd0, ready}, 32'd1);
        goto(a + 400);
        enable = 1'b1;

        expect_ev(K_RD, a + 441);
`ifdef CAM_WATCHDOG_EN
        expect_ev(K_RDY, a + 462);
        expect_ev(K_RD, a + 491);
`endif
        goto(a + 495);
        check("rd_wait_ready", {31'd0, ready}, 32'd0);
        expect_ev(K_FALL, a + 496);
        do_reset(1);

        expect_ev(K_RISE, b + 4);
        expect_ev(K_CFG, b + 13);
        pulse_done(b + 2, 1'b0);
        expect_ev(K_FALL, b + 17);
        expect_ev(K_RISE, b + 21);
        expect_ev(K_CFG, b + 30);
        pulse_done(b + 16, 1'b1);
        expect_ev(K_FALL, b + 35);
        expect_ev(K_ERR, b + 35);
        pulse_done(b + 34, 1'b1);

        goto(b + 60);
        check("fault_error", {31'd0, error}, 32'd1);
        check("fault_cam_reset", {31'd0, cam_reset}, 32'd0);
        check("fault_cam_start", {31'd0, cam_start}, 32'd0);
        pulse_done(b + 62, 1'b0);
        goto(b + 70);
        check("fault_still_error", {31'd0, error}, 32'd1);

        do_reset(2);
        expect_ev(K_RISE, b + 4);
        goto(b + 8);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
